// File: rtl/key_load_ctrl_if.sv
// Wishbone B3 classic bus bundle between the key loader and the shared
// RAM/key-register slave port.
interface key_load_ctrl_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  modport master (
    output adr, wdat, sel, cyc, stb, we, cti, bte,
    input  rdat, ack, err
  );

  modport slave (
    input  adr, wdat, sel, cyc, stb, we, cti, bte,
    output rdat, ack, err
  );
endinterface

// File: rtl/key_load_ctrl.sv
// Boot-time Wishbone master: copies the OTP key image from RAM into the
// key register window, one classic read then one classic write per word.
module key_load_ctrl #(
  parameter int          NUM_WORDS = 24,
  parameter logic [31:0] KEY_BASE  = 32'h0008_0000,
  parameter int          TIMEOUT   = 255,
  parameter int          MAX_RETRY = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start_i,
  input  logic [31:0]     src_base_i,
  key_load_ctrl_if.master wbm,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            lock_o,
  output logic [4:0]      word_cnt_o
);

  localparam logic [4:0] LAST = 5'(NUM_WORDS - 1);
  localparam logic [7:0] TMO  = 8'(TIMEOUT);
  localparam logic [3:0] RMAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, RD, WR, GAP_R, GAP_W, DONE, ERR
  } state_t;

  state_t      state, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        busy_d, err_d, lock_d, done_d;
  logic        fail, we_d, txn_d;
  logic [31:0] offs, adr_d, dat_d;

  assign wbm.cti    = 3'b000;
  assign wbm.bte    = 2'b00;
  assign word_cnt_o = cnt_q;

  always_comb begin
    state_d = state;
    src_d   = src_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    busy_d  = busy_o;
    err_d   = err_o;
    lock_d  = lock_o;
    fail    = wbm.err || (tmo_q == TMO);
    unique case (state)
      IDLE: begin
        if (start_i && !lock_o) begin
          src_d   = src_base_i;
          cnt_d   = '0;
          retry_d = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = GAP_R;
        end
      end
      GAP_R: begin
        tmo_d   = '0;
        state_d = RD;
      end
      GAP_W: begin
        tmo_d   = '0;
        state_d = WR;
      end
      RD, WR: begin
        // ack has priority over a simultaneous err
        if (wbm.ack) begin
          retry_d = '0;
          if (state == RD) begin
            data_d  = wbm.rdat;
            state_d = GAP_W;
          end else if (cnt_q == LAST) begin
            busy_d  = 1'b0;
            lock_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = GAP_R;
          end
        end else if (fail) begin
          if (retry_q == RMAX) begin
            retry_d = '0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = (state == RD) ? GAP_R : GAP_W;
          end
        end else if (tmo_q != TMO) begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      DONE, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // bus outputs are a function of the next state, so they only move
    // on transitions and stay frozen while a slave inserts waits
    offs   = {25'd0, cnt_d, 2'b00};
    we_d   = (state_d == WR);
    txn_d  = (state_d == RD) || we_d;
    done_d = (state_d == DONE);
    adr_d  = wbm.adr;
    dat_d  = wbm.wdat;
    if (state_d == RD) adr_d = src_d + offs;
    if (we_d) begin
      adr_d = KEY_BASE + offs;
      dat_d = data_d;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      src_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      retry_q  <= '0;
      tmo_q    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      lock_o   <= 1'b0;
      wbm.cyc  <= 1'b0;
      wbm.stb  <= 1'b0;
      wbm.we   <= 1'b0;
      wbm.adr  <= '0;
      wbm.wdat <= '0;
      wbm.sel  <= '0;
    end else begin
      state    <= state_d;
      src_q    <= src_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
      err_o    <= err_d;
      lock_o   <= lock_d;
      wbm.cyc  <= txn_d;
      wbm.stb  <= txn_d;
      wbm.we   <= we_d;
      wbm.adr  <= adr_d;
      wbm.wdat <= dat_d;
      wbm.sel  <= txn_d ? 4'hF : 4'h0;
    end
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Bench for key_load_ctrl: scripted Wishbone slave, transaction monitor
// and a list-based model of the expected bus traffic.
module tb_key_load_ctrl;

  localparam int          NW  = 24;
  localparam logic [31:0] KB  = 32'h0008_0000;
  localparam int          TMO = 255;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  typedef struct {
    logic [31:0] base;
    int          ws;
    int          err_word;
    bit          fixed;
    bit          exp_lock;
    bit          exp_err;
    int          exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_base = '0;
  logic        busy, done, err, lock;
  logic [4:0]  wcnt;

  key_load_ctrl_if wb();

  key_load_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start),
    .src_base_i (src_base),
    .wbm        (wb),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .lock_o     (lock),
    .word_cnt_o (wcnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // slave configuration, written only by the stimulus process
  logic [31:0] src_data [NW];
  logic [31:0] cur_base = '0;
  int          ws_cfg = 0;
  bit          blk_en = 1'b0;
  logic [31:0] blk_adr = '0;
  logic [31:0] err_adr = '0;
  int          err_budget = 0;

  // monitor state, written only by the monitor process
  int   done_cnt = 0, busy_cyc = 0, stb_cyc = 0, err_fired = 0;
  int   gap_err = 0, stab_err = 0, bus_err = 0, gap_run = 0;
  logic p_stb = 1'b0, p_cyc = 1'b0, p_term = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = '0, p_dat = '0;
  txn_t att_q[$];
  txn_t exp_q[$];

  // scripted slave: ws_cfg wait states, optional err / never-ack
  logic [7:0]  ws_cnt;
  logic [31:0] rd_off;
  logic        req, hit_blk, hit_err, ready;
  assign req     = wb.cyc & wb.stb;
  assign ready   = (ws_cnt == 8'(ws_cfg));
  assign hit_blk = blk_en & ~wb.we & (wb.adr == blk_adr);
  assign hit_err = wb.we & (wb.adr == err_adr) & (err_fired < err_budget);
  assign wb.ack  = req & ready & ~hit_blk & ~hit_err;
  assign wb.err  = req & ready & hit_err;
  assign rd_off  = (wb.adr - cur_base) >> 2;
  assign wb.rdat = (rd_off < 32'(NW)) ? src_data[rd_off[4:0]] : 32'hDEAD_BEEF;

  always @(posedge clk or posedge rst) begin
    if (rst) ws_cnt <= '0;
    else if (!req || wb.ack || wb.err) ws_cnt <= '0;
    else if (ws_cnt != 8'hFF) ws_cnt <= ws_cnt + 8'd1;
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cyc <= busy_cyc + 1;
      if (wb.stb) stb_cyc <= stb_cyc + 1;
      if (wb.err) err_fired <= err_fired + 1;
      if (wb.stb && (wb.sel != 4'hF || wb.cti != 3'd0 ||
                     wb.bte != 2'd0 || !wb.cyc))
        bus_err <= bus_err + 1;
      if (wb.stb && !p_stb) att_q.push_back('{wb.we, wb.adr, wb.wdat});
      if (wb.stb && p_stb && !p_term &&
          (wb.adr != p_adr || wb.we != p_we || wb.wdat != p_dat))
        stab_err <= stab_err + 1;
      if (wb.cyc && !p_cyc && busy && gap_run != 1)
        gap_err <= gap_err + 1;
      if (busy && !wb.cyc) gap_run <= gap_run + 1;
      else gap_run <= 0;
    end
    p_stb  <= wb.stb;
    p_cyc  <= wb.cyc;
    p_term <= wb.ack | wb.err;
    p_we   <= wb.we;
    p_adr  <= wb.adr;
    p_dat  <= wb.wdat;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic prep(input logic [31:0] base, input int ws,
                      input int err_word, input bit fixed);
    for (int i = 0; i < NW; i++)
      src_data[i] = fixed ? 32'hA000_0000 + 32'(i) : $urandom;
    cur_base = base;
    src_base = base;
    ws_cfg   = ws;
    if (err_word >= 0) begin
      err_adr    = KB + 32'(4 * err_word);
      err_budget = err_fired + 1;
    end else begin
      err_budget = err_fired;
    end
  endtask

  // expected attempt list: read word i, write it, with a repeated
  // write when that word's first write attempt is failed by the slave
  task automatic build_exp(input logic [31:0] base, input int err_word);
    exp_q = {};
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back('{1'b0, base + 32'(4 * i), 32'h0});
      if (i == err_word)
        exp_q.push_back('{1'b1, KB + 32'(4 * i), src_data[i]});
      exp_q.push_back('{1'b1, KB + 32'(4 * i), src_data[i]});
    end
  endtask

  task automatic cmp_att(input string nm, input int from);
    int   bad;
    txn_t a;
    bad = 0;
    chk({nm, "_ntxn"}, 32'(att_q.size() - from), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (from + k < att_q.size()) begin
        a = att_q[from + k];
        if (a.we !== exp_q[k].we || a.adr !== exp_q[k].adr ||
            (a.we && a.dat !== exp_q[k].dat))
          bad++;
      end
    end
    chk({nm, "_txn_seq"}, 32'(bad), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] base, input int ws,
                         input int err_word, input bit fixed,
                         input bit hold, input string nm);
    int d0, b0, from, g0, s0, u0, c;
    prep(base, ws, err_word, fixed);
    build_exp(base, err_word);
    d0 = done_cnt; b0 = busy_cyc; from = att_q.size();
    g0 = gap_err; s0 = stab_err; u0 = bus_err;
    start = 1'b1;
    c = 0;
    while (c < 20000 && done_cnt == d0 && !(c > 2 && err)) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_finished"}, 32'(c < 20000), 32'd1);
    repeat (2) @(negedge clk);
    if (!hold) start = 1'b0;
    chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_busy_cycles"}, 32'(busy_cyc - b0),
        32'((2 * NW + (err_word >= 0 ? 1 : 0)) * (ws + 2)));
    cmp_att(nm, from);
    chk({nm, "_gap"}, 32'(gap_err - g0), 32'd0);
    chk({nm, "_stable"}, 32'(stab_err - s0), 32'd0);
    chk({nm, "_sel_cti"}, 32'(bus_err - u0), 32'd0);
    chk({nm, "_flags"}, {28'd0, busy, err, lock, done}, 32'b0010);
    chk({nm, "_word_cnt"}, {27'd0, wcnt}, 32'(NW - 1));
  endtask

  vec_t vecs[6];

  initial begin
    int s0, a0, d0, c, from;

    vecs[0] = '{32'h1000, 0, -1, 1'b1, 1'b1, 1'b0, 1};
    vecs[1] = '{32'h1000, 3, -1, 1'b1, 1'b1, 1'b0, 1};
    vecs[2] = '{32'h1000, 0, 5, 1'b1, 1'b1, 1'b0, 1};
    vecs[3] = '{$urandom & 32'h0007_FFFC, int'($urandom_range(0, 2)),
                5, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{$urandom & 32'h0007_FFFC, int'($urandom_range(0, 4)),
                int'($urandom_range(0, NW - 1)), 1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{$urandom & 32'h0007_FFFC, 1, -1, 1'b0, 1'b1, 1'b0, 1};

    #1 rst = 1'b1;
    #2;
    chk("reset_bus", {wb.adr[27:0], wb.sel}, 32'd0);
    chk("reset_ctl", {22'd0, wb.cyc, wb.stb, wb.we, wb.wdat == 0,
                      busy, done, err, lock, wcnt == 0},
        32'b0000_0010_0001);
    do_reset();

    for (int v = 0; v < 6; v++) begin
      do_reset();
      do_load(vecs[v].base, vecs[v].ws, vecs[v].err_word, vecs[v].fixed,
              1'b0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_outs", v), {29'd0, lock, err, 1'b0},
          {29'd0, vecs[v].exp_lock, vecs[v].exp_err, 1'b0});
    end

    // start held through and after completion: exactly one load
    do_reset();
    do_load(32'h2000, 0, -1, 1'b0, 1'b1, "held");
    s0 = stb_cyc; a0 = att_q.size(); d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("held_no_bus", 32'(stb_cyc - s0), 32'd0);
    chk("held_no_txn", 32'(att_q.size() - a0), 32'd0);
    chk("held_no_done", 32'(done_cnt - d0), 32'd0);
    chk("held_lock", {31'd0, lock}, 32'd1);
    start = 1'b0;

    // read of word 0 never acked: three timed-out attempts then abort
    do_reset();
    prep(32'h3000, 0, -1, 1'b0);
    blk_en = 1'b1;
    blk_adr = 32'h3000;
    s0 = stb_cyc; d0 = done_cnt; from = att_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (c < 5000 && !err) begin
      @(negedge clk);
      c++;
    end
    chk("tmo_reached_err", 32'(c < 5000), 32'd1);
    repeat (2) @(negedge clk);
    chk("tmo_stb_cycles", 32'(stb_cyc - s0), 32'(3 * (TMO + 1)));
    exp_q = {};
    for (int k = 0; k < 3; k++) exp_q.push_back('{1'b0, 32'h3000, 32'h0});
    cmp_att("tmo", from);
    chk("tmo_flags", {28'd0, busy, err, lock, done}, 32'b0100);
    chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
    blk_en = 1'b0;
    do_load(32'h3000, 1, -1, 1'b0, 1'b0, "tmo_restart");

    // reset while writing word 10, then a clean reload from word 0
    do_reset();
    prep(32'h4000, 1, -1, 1'b0);
    start = 1'b1;
    c = 0;
    while (c < 2000 && !(wb.cyc && wb.we && wb.adr == KB + 32'd40)) begin
      @(negedge clk);
      c++;
    end
    chk("rst_reached_w10", 32'(c < 2000), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_bus_drop", {29'd0, wb.cyc, wb.stb, wb.we}, 32'd0);
    chk("rst_flags", {23'd0, busy, done, err, lock, wcnt}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    do_load(32'h4000, 2, -1, 1'b0, 1'b0, "rst_reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_load_ctrl.md
Name: key_load_ctrl

Overview:
- Wishbone B3 master FSM that loads all six 128-bit key/coefficient registers from a source region in memory after boot.
- Source region: OTP/fuse image held in RAM.
- Destination: the key register window at 0x80000–0x8005C, written as 24 single 32-bit words.
- Connects to one master port of the shared RAM/key-register slave and to the boot sequencer's start/done handshake.

Parameters:
- NUM_WORDS, 24, number of 32-bit words to transfer (must be 1..31).
- KEY_BASE, 32'h0008_0000, destination address of word 0; word i goes to KEY_BASE+4*i.
- TIMEOUT, 255, cycles with stb high and no ack/err before the transaction counts as failed (8-bit counter).
- MAX_RETRY, 2, retries per transaction after err/timeout before aborting.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- start_i  in  1  level; a load is requested while high in IDLE
- src_base_i  in  32  source address of word 0, word aligned; sampled on the start cycle
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_sel_o  out  4  byte select; always 4'hF during a transaction
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  write enable
- wbm_cti_o  out  3  always 3'b000 (classic)
- wbm_bte_o  out  2  always 2'b00
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  error
- busy_o  out  1  high from the start cycle until DONE/ERR
- done_o  out  1  one-cycle pulse on successful completion
- err_o  out  1  sticky abort flag; cleared by next accepted start
- lock_o  out  1  set on successful completion; while set, start_i is ignored until reset
- word_cnt_o  out  5  index of current/next word

Behaviour:
- Reset (async): state=IDLE; cyc/stb/we=0; adr/dat/sel=0; busy/done/err/lock=0; word_cnt=0; retry and timeout counters=0.
- States: IDLE, RD, WR, GAP_R, GAP_W, DONE, ERR.
- IDLE:
  - If start_i & !lock_o: latch src_base_i, word_cnt=0, err_o=0, busy_o=1, go to GAP_R.
  - Otherwise stay in IDLE.
- GAP_R / GAP_W: one cycle with cyc=stb=0, so the shared arbiter can re-arbitrate; then go to RD / WR.
- RD:
  - cyc=stb=1, we=0, adr=src_base+4*word_cnt.
  - On ack: capture wbm_dat_i into data_q, reset retry count, go to GAP_W.
- WR:
  - cyc=stb=1, we=1, adr=KEY_BASE+4*word_cnt, dat=data_q.
  - On ack with word_cnt==NUM_WORDS-1: go to DONE.
  - On ack otherwise: word_cnt+1, reset retry count, go to GAP_R.
- Failure, in RD or WR:
  - Failure is wbm_err_i, or the timeout counter reaching TIMEOUT.
  - ack and err in the same cycle: ack wins.
  - On failure: drop cyc/stb for one cycle (via the matching GAP state), then reissue the same transaction with the same address/data.
  - After MAX_RETRY retries, a further failure goes to ERR.
- Timeout counter:
  - Clears on entry to RD/WR.
  - Increments each cycle stb is high without ack/err.
  - Saturates at TIMEOUT.
- Output timing: outputs are registered; cyc/stb/we/adr/dat change only on state transitions, and are held stable while waiting for ack.
- DONE (one cycle): done_o=1, lock_o<=1, busy_o<=0, cyc=0, go to IDLE.
- ERR (one cycle): err_o<=1, busy_o<=0, cyc=0, go to IDLE. A later start retries the whole load from word 0. lock_o stays 0.
- start_i while busy: ignored. start_i while locked: no bus activity.
- Reset mid-transfer: all outputs return to reset values immediately; cyc drops without waiting for ack. A partially written key window is left as-is.
- word_cnt is 5-bit; the NUM_WORDS≤31 limit means it never wraps.

Test Plan:
- Zero-wait slave, src_base=0x1000, source words 0xA0000000+i:
  - Exact order: 24 reads at 0x1000..0x105C interleaved with 24 writes at 0x80000..0x8005C.
  - Write data = read data.
  - cyc low exactly 1 cycle between transactions.
  - done_o pulses once; lock_o=1.
- Slave inserts 3 wait states on every ack:
  - adr/dat/we stable during waits.
  - Total = 48 transactions, each 4 cycles + 1 gap.
  - done_o asserted.
- err on first attempt of write word 5:
  - Same address/data reissued after a 1-cycle gap.
  - Load completes; err_o=0.
- Slave never acks read word 0:
  - Timeout after 255 cycles, repeated 3 times total.
  - ERR: err_o=1, busy_o=0, lock_o=0.
  - A new start restarts from word 0.
- start_i held high through and after completion: no second load, no bus activity, lock_o=1.
- Assert wb_rst_i during write of word 10:
  - cyc/stb/we drop in the same cycle.
  - All flags and word_cnt_o=0.
  - A new start reloads from word 0.
